// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide,
// 32 iterations per operation, fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic [2:0]        op_q;
  logic              a_neg_q, b_neg_q;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   sreg;
  logic [CW-1:0]     cnt;

  logic              accept, a_signed, b_signed, div_zero, div_ovf, fast;
  logic [XLEN-1:0]   mag1, mag2, fast_result, final_result;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_next, prod;
  logic [XLEN-1:0]   quo, rem;

  assign accept = start && !flush && (state == IDLE || state == DONE);

  // Operand decode at the accepting edge; only signs and magnitudes are kept.
  always_comb begin
    a_signed = (~funct3[2] & ~(funct3[1] & funct3[0])) | (funct3[2] & ~funct3[0]);
    b_signed = (~funct3[2] & ~funct3[1]) | (funct3[2] & ~funct3[0]);
    mag1     = (a_signed && in1[XLEN-1]) ? -in1 : in1;
    mag2     = (b_signed && in2[XLEN-1]) ? -in2 : in2;
    div_zero = (in2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1);
    fast     = funct3[2] && (div_zero || div_ovf);
    if (div_zero)
      fast_result = funct3[1] ? in1 : '1;
    else
      fast_result = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum  = acc[0] ? ({1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, sreg})
                      : {1'b0, acc[2*XLEN-1:XLEN]};
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b00, sreg};
    if (div_diff[XLEN+1])
      div_next = {acc[2*XLEN-2:0], 1'b0};
    else
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_next = (state == DIV) ? div_next : mul_next;
  end

  // Sign fix-up of the final iteration's output.
  always_comb begin
    prod = (a_neg_q ^ b_neg_q) ? -acc_next : acc_next;
    quo  = acc_next[XLEN-1:0];
    rem  = acc_next[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (op_q[1])
        final_result = a_neg_q ? -rem : rem;
      else
        final_result = (a_neg_q ^ b_neg_q) ? -quo : quo;
    end else begin
      final_result = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start)
          state_nxt = fast ? DONE : (funct3[2] ? DIV : MUL);
        else if (state == DONE)
          state_nxt = IDLE;
      end
      MUL, DIV: if (cnt == CNT_LAST) state_nxt = DONE;
      default:  state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_comb begin
    busy = (state == MUL) || (state == DIV);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      acc     <= '0;
      sreg    <= '0;
      cnt     <= '0;
      result  <= '0;
    end else if (accept) begin
      op_q    <= funct3;
      a_neg_q <= a_signed && in1[XLEN-1];
      b_neg_q <= b_signed && in2[XLEN-1];
      acc     <= {{XLEN{1'b0}}, mag1};
      sreg    <= mag2;
      cnt     <= '0;
      if (fast) result <= fast_result;
    end else if (busy && !flush) begin
      acc <= acc_next;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_LAST) result <= final_result;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes expected result and done cycle,
// monitor pops and compares on every done pulse.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] in1, in2;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .in1(in1), .in2(in2),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_res = '0;
  int          busy_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb_, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = $signed(a);
    sb_ = $signed(b);
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb_; return p[31:0]; end
      3'd1: begin p = sa * sb_; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb_; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb_; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 0) return 1'b1;
    return !f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no done (result 0x%08h, t=%0t)", result, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit push);
    if (push) begin
      exp_t e;
      e.res = ref_model(f, a, b);
      e.cyc = cyc + 1 + (is_fast(f, a, b) ? 0 : 32);
      sb.push_back(e);
      last_res = e.res;
    end
    start  = 1'b1;
    funct3 = f;
    in1    = a;
    in2    = b;
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    in1    = $urandom;
    in2    = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    issue(f, a, b, 1'b1);
    wait_done();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; in1 = '0; in2 = '0;
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    check("mul_busy_cycles", busy_cnt, 32'd32);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd100, 32'd7);
    run_op(3'd7, 32'd100, 32'd7);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'd1234, 32'd0);
    @(negedge clk);

    // Flush at iteration 10 of a DIV, with a concurrent start that must be dropped.
    issue(3'd4, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = 3'd5; in2 = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_done", {31'b0, done}, 32'd0);
    check("flush_result", result, last_res);
    repeat (40) @(negedge clk);
    check("flush_result_hold", result, last_res);

    // Flush and start together in IDLE: start dropped.
    flush = 1'b1; start = 1'b1; funct3 = 3'd5; in1 = 32'd9; in2 = 32'd0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    check("flush_start_done", {31'b0, done}, 32'd0);
    check("flush_start_result", result, last_res);
    @(negedge clk);

    // Start during busy is ignored.
    issue(3'd0, 32'd123, 32'd456, 1'b1);
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = 3'd5; in1 = 32'd77; in2 = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    // Start in the DONE cycle begins a new op directly.
    run_op(3'd7, 32'd50, 32'd8);
    run_op(3'd5, 32'd8, 32'd0);
    run_op(3'd0, 32'hFFFF_FFFF, 32'd2);
    check("back_to_back_busy", busy_cnt, 32'd32);
    @(negedge clk);

    // Asynchronous reset at iteration 20 of a MUL.
    issue(3'd0, 32'd11, 32'd13, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_busy", {31'b0, busy}, 32'd0);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_res = '0;
    @(negedge clk);
    run_op(3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 200; i++) begin
      run_op(3'($urandom), pick(), pick());
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 supported.
REQ-002 SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have start  input  1  request new operation; sampled on clk rising edge.
REQ-005 SHALL have funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have in1  input  32  operand rs1 (same execute-stage operand bus as the ALU).
REQ-007 SHALL have in2  input  32  operand rs2.
REQ-008 SHALL have flush  input  1  pipeline kill; aborts any in-flight operation.
REQ-009 SHALL have busy  output  1  high while operation in progress; pipeline stalls on it.
REQ-010 SHALL have done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have result  output  32  operation result; feeds execute-stage result mux next to ALU result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-013 SHALL latch funct3, in1, in2 at the edge where start=1 is accepted; later operand changes SHALL NOT affect the operation.
REQ-014 SHALL accept start only in IDLE or DONE; start in MUL/DIV SHALL be ignored.
REQ-015 IDLE/DONE + start, funct3[2]=0 -> MUL; funct3[2]=1 and not special case -> DIV.
REQ-016 MUL/DIV SHALL run exactly 32 iteration cycles (iteration counter 0..31), then -> DONE.
REQ-017 DONE SHALL last one cycle with done=1, then -> IDLE, unless start=1 (new op accepted directly).
REQ-018 busy SHALL be 1 exactly in MUL and DIV; done SHALL be 1 exactly in DONE.
REQ-019 Latency: start accepted at edge E0 -> done=1 in the cycle after edge E32 (33 cycles start-to-done).
REQ-020 Multiply: unsigned shift-add on operand magnitudes; 64-bit product negated when result sign is negative.
REQ-021 Signedness: MUL/MULH signed x signed; MULHSU signed in1 x unsigned in2; MULHU unsigned x unsigned.
REQ-022 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-023 Divide: restoring division on magnitudes; quotient sign = sign(in1) XOR sign(in2); remainder sign = sign(in1) (DIV/REM only).
REQ-024 Divide by zero (in2=0) SHALL take fast path: IDLE -> DONE at E0, done in the cycle after E0; DIV/DIVU quotient 0xFFFFFFFF, REM/REMU result = in1.
REQ-025 Signed overflow (DIV/REM, in1=0x80000000, in2=0xFFFFFFFF) SHALL take the fast path; DIV result 0x80000000, REM result 0.
REQ-026 result SHALL update only on entry to DONE and hold until the next DONE.
REQ-027 flush=1 SHALL force IDLE at the next edge from any state: no done pulse, result unchanged.
REQ-028 flush and start in same cycle: flush SHALL win; start dropped.
REQ-029 Internal datapath SHALL be 64-bit accumulator/remainder plus 32-bit shift registers and a 5-bit counter; no combinational 32x32 multiplier.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, busy=0, done=0, result=0x00000000, counter=0, latched operands=0.
REQ-031 rst asserted mid-operation SHALL abort with no done pulse; first start after release SHALL behave as from IDLE.

Verification
REQ-032 MUL in1=7, in2=0xFFFFFFFD (-3) -> done 33 cycles after start, result 0xFFFFFFEB; busy high for 32 cycles.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU 5/0 -> done in the cycle after start, result 0xFFFFFFFF; REM 0x80000000/0xFFFFFFFF -> done in the cycle after start, result 0.
REQ-036 flush at iteration 10 of a DIV -> IDLE next cycle, no done, result keeps prior value; start during busy ignored; start in DONE cycle begins new op.
REQ-037 rst pulse at iteration 20 of MUL -> busy=0, done=0, result=0 immediately; next MUL 3x4 -> 12.
